dct16_out_reorder: RTL

Output reorder buffer directly downstream of `dct16_core`. It accepts the core's 16-sample DCT frames, which arrive in 4-bit bit-reversed coefficient order, one sample per `in_valid` with no backpressure. It emits each frame in natural order X(0)..X(15) on a valid/ready interface. A two-bank ping-pong store decouples the core's free-running output from a stalling consumer, such as the 2D transpose/row stage or a bus master.

---
 rtl/dct16_out_reorder.sv | 117 +++++++++++
 1 files changed

// File: rtl/dct16_out_reorder.sv
// Natural-order reorder buffer behind dct16_core: ping-pong store of two 16-sample frames.
// Optional sticky frame-drop flag: define DCT16_REORDER_OVF_EN.
module dct16_out_reorder #(
  parameter int DATA_WIDTH = 12,
  parameter bit IN_BITREV  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_sample,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_sample,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_index,
  output logic                  out_last
`ifdef DCT16_REORDER_OVF_EN
  ,
  output logic                  ovf_flag,
  input  logic                  ovf_clr
`endif
);

  logic [DATA_WIDTH-1:0] mem [2][16];
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wbank;
  logic       rbank;
  logic       disc;
  logic [3:0] wcnt;
  logic [3:0] rcnt;
  logic [3:0] waddr;
  logic       frame_start;
  logic       disc_start;
  logic       wr_en;
  logic       wr_done;
  logic       rd_fire;
  logic       rd_done;

  // Write/read control decode from registered state.
  always_comb begin
    frame_start = (wcnt == 4'd0);
    disc_start  = in_valid & frame_start & full[wbank];
    wr_en       = in_valid & (frame_start ? ~full[wbank] : ~disc);
    wr_done     = in_valid & (wcnt == 4'd15) & ~disc;
    rd_fire     = full[rbank] & out_ready;
    rd_done     = rd_fire & (rcnt == 4'd15);
    if (IN_BITREV)
      waddr = {wcnt[0], wcnt[1], wcnt[2], wcnt[3]};
    else
      waddr = wcnt;
  end

  // Bank occupancy: writer and reader touch different bits when both complete.
  always_comb begin
    full_nxt = full;
    if (rd_done)
      full_nxt[rbank] = 1'b0;
    if (wr_done)
      full_nxt[wbank] = 1'b1;
  end

  // Write side: position counter, discard decision, bank toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= 4'd0;
      disc  <= 1'b0;
      wbank <= 1'b0;
    end else if (in_valid) begin
      wcnt <= wcnt + 4'd1;
      if (frame_start)
        disc <= full[wbank];
      else if (wcnt == 4'd15)
        disc <= 1'b0;
      if (wr_done)
        wbank <= ~wbank;
    end
  end

  // Read side: drain pointer and bank toggle; occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt  <= 4'd0;
      rbank <= 1'b0;
      full  <= 2'b00;
    end else begin
      full <= full_nxt;
      if (rd_fire)
        rcnt <= rcnt + 4'd1;
      if (rd_done)
        rbank <= ~rbank;
    end
  end

  // Sample store, not reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wbank][waddr] <= in_sample;
  end

`ifdef DCT16_REORDER_OVF_EN
  // Sticky drop flag; a new drop wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_flag <= 1'b0;
    else if (disc_start)
      ovf_flag <= 1'b1;
    else if (ovf_clr)
      ovf_flag <= 1'b0;
  end
`endif

  assign out_valid  = full[rbank];
  assign out_sample = mem[rbank][rcnt];
  assign out_index  = rcnt;
  assign out_last   = full[rbank] & (rcnt == 4'd15);

endmodule
